wb_intercon_rr: RTL
===================

Name: wb_intercon_rr

Overview:
- Parametrised Wishbone shared-bus interconnect: 2 masters (LM32 instruction/data), up to 16 slaves decoded on upper address bits.
- Adds over the fixed 5-slave crossbar:
  - registered round-robin arbitration;
  - per-slave populate mask;
  - error response for unmapped addresses;
  - bus-timeout watchdog;
  - error capture registers.
- Sits between lm32_cpu and all peripherals in the system top level.

Parameters:
- NUM_SLAVES, 8, number of slave ports (1..16).
- DEC_W, 3, address bits used for decode (adr[31:32-DEC_W]); 2**DEC_W >= NUM_SLAVES.
- SLAVE_EN, 8'h1F, bit i = slave i populated; unpopulated or index >= NUM_SLAVES is unmapped.
- TIMEOUT, 255, stb-without-ack cycles before a timeout error (>= 2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- m0_adr_i / m1_adr_i  in  32  master address
- m0_dat_i / m1_dat_i  in  32  master write data
- m0_dat_o / m1_dat_o  out  32  read data to master
- m0_sel_i / m1_sel_i  in  4  byte selects
- m0_we_i / m1_we_i  in  1  write enable
- m0_cyc_i / m1_cyc_i  in  1  cycle
- m0_stb_i / m1_stb_i  in  1  strobe
- m0_ack_o / m1_ack_o  out  1  acknowledge
- m0_err_o / m1_err_o  out  1  error termination
- s_adr_o  out  32  shared slave address
- s_dat_o  out  32  shared write data
- s_sel_o  out  4  shared byte selects
- s_we_o  out  1  shared write enable
- s_cyc_o  out  NUM_SLAVES  per-slave cycle
- s_stb_o  out  NUM_SLAVES  per-slave strobe
- s_dat_i  in  32*NUM_SLAVES  slave read data; slave i at [32i+31:32i]
- s_ack_i  in  NUM_SLAVES  per-slave ack
- err_adr_o  out  32  address of last errored transfer
- err_cnt_o  out  8  saturating error count
- timeout_o  out  1  one-cycle pulse on watchdog expiry

Behaviour:
Reset (rst low, asynchronous):
- State IDLE, last_grant=1.
- All s_cyc_o/s_stb_o/m*_ack_o/m*_err_o/timeout_o = 0.
- err_adr_o=0, err_cnt_o=0, timeout counter=0.
- Assertion mid-transfer drops all strobes immediately; the transfer is abandoned with no ack or err.

Arbiter FSM (IDLE, G0, G1), registered:
- IDLE:
  - only m0_cyc -> G0; only m1_cyc -> G1;
  - both -> the master not equal to last_grant;
  - none -> stay.
  - One cycle of arbitration latency from IDLE.
- Gx:
  - while mx_cyc high, stay. The grant is held across multi-beat and locked cycles.
  - mx_cyc low and other master requesting -> G(other) directly (no IDLE bubble).
  - Else -> IDLE.
  - On leaving Gx, last_grant=x.
- Non-granted master: ack/err held 0, dat_o=0, inputs ignored.

Decode (combinational from granted master):
- idx = adr[31:32-DEC_W].
- Shared s_* outputs follow the granted master.
- s_cyc_o[idx] = cyc, s_stb_o[idx] = stb, only if idx is mapped; all other bits 0.
- m_ack_o = s_ack_i[idx] & stb.
- m_dat_o = s_dat_i slice idx.
- Acks from unselected slaves are ignored.

Unmapped access:
- No slave strobed.
- m_err_o asserted one cycle after stb (registered), for one cycle.
- err_adr_o captured; err_cnt_o incremented.

Watchdog:
- Counter increments each cycle granted stb=1 with no ack/err; clears on ack, err or stb=0.
- On reaching TIMEOUT:
  - m_err_o=1 and timeout_o=1 for one cycle;
  - s_stb_o forced 0 that cycle;
  - counter clears;
  - err_adr_o captured; err_cnt_o incremented.
- Ack arriving in the expiry cycle wins: ack passed, no err, no count.

err_cnt_o:
- Saturates at 255.
- Capture and increment happen in the same cycle.

Decomposition:
- Package wb_intercon_pkg: FSM state encoding (IDLE/G0/G1), master-index constants, log2 helper function.
- Sub-module wb_rr_arbiter2: the FSM plus last_grant; outputs the one-hot grant.
- Decode, mux and watchdog stay in the top module.

Test Plan:
- m1 read 0x20000004; slave1 acks 2 cycles after stb with 0xDEADBEEF -> s_stb_o=8'h02, m1_dat_o=0xDEADBEEF with m1_ack_o, m0_ack_o=0.
- m0 and m1 assert cyc in the same cycle from IDLE after reset -> G0 first (last_grant=1). On m0 cyc drop -> G1 next cycle with no IDLE; repeat the collision -> G1 no longer favoured, G0 granted.
- m1 access to 0xE0000000 with SLAVE_EN=8'h1F -> no s_stb_o bit set, m1_err_o one cycle later, err_adr_o=0xE0000000, err_cnt_o=1.
- Slave2 never acks, TIMEOUT=16 -> after 16 stb cycles: m_err_o=1, timeout_o=1, s_stb_o[2]=0 that cycle, err_cnt_o increments.
- Slave2 acks exactly in the expiry cycle -> ack delivered, no err, timeout_o=0, err_cnt_o unchanged.
- rst low mid-transfer on slave3 -> s_cyc_o=0 immediately, FSM IDLE, err_cnt_o=0. After release, 256 forced errors -> err_cnt_o stays 255.

Source files
------------

// File: rtl/wb_intercon_pkg.sv
// +----------------------------------------------------------------------+
// | wb_intercon_pkg : shared types/constants for the Wishbone RR intercon |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package wb_intercon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } arb_state_e;

  localparam logic MST0 = 1'b0;
  localparam logic MST1 = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_rr_arbiter2.sv
// +----------------------------------------------------------------------+
// | wb_rr_arbiter2 : registered two-master round-robin arbiter            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module wb_rr_arbiter2
  import wb_intercon_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  arb_state_e state_q;
  logic       last_q;
  logic [1:0] grant_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      last_q  <= MST1;
      grant_q <= 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // On a collision the master that did not hold the bus last wins
          if (req_i[0] && (!req_i[1] || last_q == MST1)) begin
            state_q <= ST_G0;
            grant_q <= 2'b01;
          end else if (req_i[1]) begin
            state_q <= ST_G1;
            grant_q <= 2'b10;
          end
        end
        ST_G0: begin
          if (!req_i[0]) begin
            last_q <= MST0;
            if (req_i[1]) begin
              state_q <= ST_G1;
              grant_q <= 2'b10;
            end else begin
              state_q <= ST_IDLE;
              grant_q <= 2'b00;
            end
          end
        end
        ST_G1: begin
          if (!req_i[1]) begin
            last_q <= MST1;
            if (req_i[0]) begin
              state_q <= ST_G0;
              grant_q <= 2'b01;
            end else begin
              state_q <= ST_IDLE;
              grant_q <= 2'b00;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  assign grant_o = grant_q;

endmodule

`default_nettype wire

// File: rtl/wb_intercon_rr.sv
// +----------------------------------------------------------------------+
// | wb_intercon_rr : 2-master shared-bus Wishbone intercon with decode,   |
// | unmapped-error, watchdog and error capture.  Rev 1.0                  |
// +----------------------------------------------------------------------+
`default_nettype none

module wb_intercon_rr
  import wb_intercon_pkg::*;
#(
  parameter int          NUM_SLAVES = 8,
  parameter int          DEC_W      = 3,
  parameter logic [15:0] SLAVE_EN   = 16'h001F,
  parameter int          TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             m0_adr_i,
  input  logic [31:0]             m0_dat_i,
  output logic [31:0]             m0_dat_o,
  input  logic [3:0]              m0_sel_i,
  input  logic                    m0_we_i,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  input  logic [31:0]             m1_adr_i,
  input  logic [31:0]             m1_dat_i,
  output logic [31:0]             m1_dat_o,
  input  logic [3:0]              m1_sel_i,
  input  logic                    m1_we_i,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic [31:0]             s_adr_o,
  output logic [31:0]             s_dat_o,
  output logic [3:0]              s_sel_o,
  output logic                    s_we_o,
  output logic [NUM_SLAVES-1:0]   s_cyc_o,
  output logic [NUM_SLAVES-1:0]   s_stb_o,
  input  logic [32*NUM_SLAVES-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]   s_ack_i,
  output logic [31:0]             err_adr_o,
  output logic [7:0]              err_cnt_o,
  output logic                    timeout_o
);

  localparam int NDEC = 1 << DEC_W;
  localparam int WD_W = clog2(TIMEOUT + 1);

  logic [1:0]       w_gnt;
  logic [31:0]      w_adr;
  logic             w_cyc, w_stb;
  logic [DEC_W-1:0] w_idx;
  logic [NDEC-1:0]  w_map_vec, w_ack_vec;
  logic [31:0]      w_dat_vec [NDEC];
  logic             w_mapped, w_sack, w_ack, w_expire, w_unmap_set, w_err_evt;
  logic [31:0]      w_sdat;

  logic [WD_W-1:0]  wd_q, wd_d;
  logic [1:0]       err_q, err_d;
  logic [31:0]      err_adr_q;
  logic [7:0]       err_cnt_q;

  wb_rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   ({m1_cyc_i, m0_cyc_i}),
    .grant_o (w_gnt)
  );

  assign w_adr   = w_gnt[1] ? m1_adr_i : m0_adr_i;
  assign s_adr_o = w_adr;
  assign s_dat_o = w_gnt[1] ? m1_dat_i : m0_dat_i;
  assign s_sel_o = w_gnt[1] ? m1_sel_i : m0_sel_i;
  assign s_we_o  = w_gnt[1] ? m1_we_i  : m0_we_i;
  assign w_cyc   = (w_gnt[0] & m0_cyc_i) | (w_gnt[1] & m1_cyc_i);
  assign w_stb   = (w_gnt[0] & m0_stb_i) | (w_gnt[1] & m1_stb_i);
  assign w_idx   = w_adr[31 -: DEC_W];

  // Widen the slave-side vectors to the full decode space; holes read as unmapped
  for (genvar i = 0; i < NDEC; i++) begin : g_dec
    if (i < NUM_SLAVES) begin : g_port
      assign w_map_vec[i] = SLAVE_EN[i];
      assign w_ack_vec[i] = s_ack_i[i];
      assign w_dat_vec[i] = s_dat_i[32*i +: 32];
    end else begin : g_hole
      assign w_map_vec[i] = 1'b0;
      assign w_ack_vec[i] = 1'b0;
      assign w_dat_vec[i] = 32'h0;
    end
  end

  assign w_mapped    = w_map_vec[w_idx];
  assign w_sack      = w_ack_vec[w_idx] & w_mapped;
  assign w_sdat      = w_dat_vec[w_idx];
  assign w_ack       = w_sack & w_stb;
  assign w_expire    = w_stb & w_mapped & ~w_sack & (wd_q == WD_W'(TIMEOUT));
  assign w_unmap_set = w_stb & ~w_mapped & ~(|(err_q & w_gnt));
  assign w_err_evt   = w_unmap_set | w_expire;
  assign err_d       = w_gnt & {2{w_unmap_set}};
  assign wd_d        = (!w_stb || !w_mapped || w_sack || w_expire) ? '0 : wd_q + 1'b1;

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_strobe
    assign s_cyc_o[i] = w_cyc & w_mapped & (w_idx == DEC_W'(i));
    assign s_stb_o[i] = w_stb & w_mapped & (w_idx == DEC_W'(i)) & ~w_expire;
  end

  assign m0_ack_o  = w_gnt[0] & w_ack;
  assign m1_ack_o  = w_gnt[1] & w_ack;
  assign m0_err_o  = err_q[0] | (w_gnt[0] & w_expire);
  assign m1_err_o  = err_q[1] | (w_gnt[1] & w_expire);
  assign m0_dat_o  = w_gnt[0] ? w_sdat : 32'h0;
  assign m1_dat_o  = w_gnt[1] ? w_sdat : 32'h0;
  assign timeout_o = w_expire;
  assign err_adr_o = err_adr_q;
  assign err_cnt_o = err_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q      <= '0;
      err_q     <= 2'b00;
      err_adr_q <= 32'h0;
      err_cnt_q <= 8'h0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
      if (w_err_evt) begin
        err_adr_q <= w_adr;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire
